// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between four byte requesters,
// with per-requester lock for multi-byte messages and a tx_done watchdog.
module uart_tx_arbiter #(
    parameter int unsigned timeout = 20000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  req,
    input  logic [3:0]  lock,
    input  logic [31:0] data,
    output logic [3:0]  ack,
    output logic [3:0]  done,
    output logic [3:0]  err,
    output logic [3:0]  grant,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_done
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    localparam logic [15:0] LIMIT = 16'(timeout - 1);

    state_t      state, state_next;
    logic [1:0]  last, last_next;
    logic        held, held_next;
    logic [15:0] count, count_next;
    logic [3:0]  grant_next, ack_next, done_next, err_next;
    logic [7:0]  tx_data_next;
    logic        tx_wr_next;
    logic [1:0]  winner, idx, sel;
    logic        found, relock;

    // First requester at or after last+1, wrapping; k=4 lands back on last.
    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = last;
        for (int k = 1; k <= 4; k++) begin
            idx = last + k[1:0];
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // held is dropped on a timeout so a stuck owner cannot keep the channel by lock.
    assign relock = held && req[last] && lock[last];
    assign sel    = relock ? last : winner;

    always_comb begin
        state_next   = state;
        last_next    = last;
        held_next    = held;
        count_next   = count;
        grant_next   = grant;
        ack_next     = 4'b0000;
        done_next    = 4'b0000;
        err_next     = 4'b0000;
        tx_data_next = tx_data;
        tx_wr_next   = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    tx_data_next = data[{sel, 3'b000} +: 8];
                    grant_next   = 4'b0001 << sel;
                    last_next    = sel;
                    held_next    = 1'b1;
                    state_next   = SEND;
                end else if (held && lock[last]) begin
                    grant_next = 4'b0001 << last;
                end else begin
                    grant_next = 4'b0000;
                end
            end
            SEND: begin
                tx_wr_next = 1'b1;
                ack_next   = grant;
                count_next = 16'd0;
                state_next = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    done_next  = grant;
                    state_next = IDLE;
                end else if (count == LIMIT) begin
                    err_next   = grant;
                    held_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    count_next = count + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            last    <= 2'd3;
            held    <= 1'b0;
            count   <= 16'd0;
            grant   <= 4'b0000;
            ack     <= 4'b0000;
            done    <= 4'b0000;
            err     <= 4'b0000;
            tx_data <= 8'h00;
            tx_wr   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            last    <= last_next;
            held    <= held_next;
            count   <= count_next;
            grant   <= grant_next;
            ack     <= ack_next;
            done    <= done_next;
            err     <= err_next;
            tx_data <= tx_data_next;
            tx_wr   <= tx_wr_next;
            busy    <= (state_next != IDLE);
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance a (timeout 200) for arbitration,
// instance b (timeout 50) for watchdog behaviour; the idle instance is held in reset.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst_a, rst_b, use_b;
    logic [3:0]  req, lock;
    logic [31:0] data;
    logic        tx_done;

    logic [3:0] a_ack, a_done, a_err, a_grant, b_ack, b_done, b_err, b_grant;
    logic       a_busy, a_tx_wr, b_busy, b_tx_wr;
    logic [7:0] a_tx_data, b_tx_data;

    logic [3:0] ack_o, done_o, err_o, grant_o;
    logic       busy_o, tx_wr_o;
    logic [7:0] tx_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.timeout(200)) dut_a (
        .sys_clk(clk), .sys_rst(rst_a), .req(req), .lock(lock), .data(data),
        .ack(a_ack), .done(a_done), .err(a_err), .grant(a_grant), .busy(a_busy),
        .tx_data(a_tx_data), .tx_wr(a_tx_wr), .tx_done(tx_done)
    );

    uart_tx_arbiter #(.timeout(50)) dut_b (
        .sys_clk(clk), .sys_rst(rst_b), .req(req), .lock(lock), .data(data),
        .ack(b_ack), .done(b_done), .err(b_err), .grant(b_grant), .busy(b_busy),
        .tx_data(b_tx_data), .tx_wr(b_tx_wr), .tx_done(tx_done)
    );

    assign ack_o     = use_b ? b_ack     : a_ack;
    assign done_o    = use_b ? b_done    : a_done;
    assign err_o     = use_b ? b_err     : a_err;
    assign grant_o   = use_b ? b_grant   : a_grant;
    assign busy_o    = use_b ? b_busy    : a_busy;
    assign tx_wr_o   = use_b ? b_tx_wr   : a_tx_wr;
    assign tx_data_o = use_b ? b_tx_data : a_tx_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, ack_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_txwr"}, tx_wr_o, 0);
        chk({tag, "_txdata"}, tx_data_o, 0);
    endtask

    // Called in IDLE with requests applied; returns in the done cycle.
    task automatic serve(input string tag, input logic [3:0] g, input logic [7:0] b,
                         input int lat, input logic [3:0] req_after);
        bit ok;
        tick();
        chk({tag, "_grant"}, grant_o, g);
        chk({tag, "_send_nowr"}, tx_wr_o, 0);
        tick();
        chk({tag, "_wr"}, tx_wr_o, 1);
        chk({tag, "_ack"}, ack_o, g);
        chk({tag, "_data"}, tx_data_o, b);
        ok = 1'b1;
        for (int i = 0; i < lat; i++) begin
            tick();
            if (i == 0) req = req_after;
            if (tx_wr_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 4'b0 ||
                ack_o !== 4'b0 || grant_o !== g || tx_data_o !== b) ok = 1'b0;
        end
        chk({tag, "_wait_stable"}, ok, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({tag, "_done"}, done_o, g);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_idle"}, busy_o, 0);
    endtask

    initial begin
        bit ok;
        rst_a = 1'b1; rst_b = 1'b1; use_b = 1'b0;
        req = 4'b0; lock = 4'b0; data = 32'h0; tx_done = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_a = 1'b0;
        tick();

        // round-robin from requester 0
        data = 32'h13121110;
        req  = 4'b1111;
        serve("rr0", 4'b0001, 8'h10, 3, 4'b1111);
        serve("rr1", 4'b0010, 8'h11, 4, 4'b1111);
        serve("rr2", 4'b0100, 8'h12, 5, 4'b1111);
        serve("rr3", 4'b1000, 8'h13, 2, 4'b1111);
        serve("rr4", 4'b0001, 8'h10, 3, 4'b0000);

        // stray tx_done in IDLE
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("stray_idle_done", done_o, 0);
        chk("stray_idle_busy", busy_o, 0);
        chk("stray_idle_grant", grant_o, 0);
        tick();
        chk("stray_idle_done2", done_o, 0);

        // single byte from requester 2, completion 100 cycles after tx_wr
        data = 32'h00410000;
        req  = 4'b0100;
        serve("single", 4'b0100, 8'h41, 100, 4'b0000);
        tick();
        chk("single_grant_clr", grant_o, 0);

        // stray tx_done during SEND
        req = 4'b0100;
        tick();
        chk("straysend_grant", grant_o, 4'b0100);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        req = 4'b0000;
        chk("straysend_wr", tx_wr_o, 1);
        chk("straysend_done", done_o, 0);
        tick();
        chk("straysend_done2", done_o, 0);
        chk("straysend_busy", busy_o, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("straysend_final", done_o, 4'b0100);

        // lock: requester 1 keeps the channel for three bytes while requester 0 waits
        data = 32'h00002220;
        req  = 4'b0010;
        lock = 4'b0010;
        serve("lock1", 4'b0010, 8'h22, 3, 4'b0011);
        serve("lock2", 4'b0010, 8'h22, 3, 4'b0011);
        serve("lock3", 4'b0010, 8'h22, 3, 4'b0011);
        lock = 4'b0000;
        serve("unlock", 4'b0001, 8'h20, 3, 4'b0000);
        lock = 4'b0001;
        tick();
        chk("lock_hold_grant", grant_o, 4'b0001);
        chk("lock_hold_busy", busy_o, 0);
        lock = 4'b0000;
        tick();
        chk("lock_rel_grant", grant_o, 0);

        // reset during WAIT
        data = 32'h13121110;
        req  = 4'b0100;
        tick();
        tick();
        chk("rstwait_wr", tx_wr_o, 1);
        req = 4'b0000;
        tick();
        tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk_all_zero("rstwait");
        req = 4'b1111;
        serve("post_rst", 4'b0001, 8'h10, 2, 4'b0000);

        // watchdog on instance b (timeout 50)
        rst_a = 1'b1;
        rst_b = 1'b0;
        use_b = 1'b1;
        req = 4'b0000;
        tick();
        chk("b_reset_grant", grant_o, 0);
        data = 32'h55AA0077;
        req  = 4'b1000;
        lock = 4'b1000;
        tick();
        chk("to_grant", grant_o, 4'b1000);
        tick();
        chk("to_wr", tx_wr_o, 1);
        chk("to_ack", ack_o, 4'b1000);
        req = 4'b0000;
        ok = 1'b1;
        for (int i = 0; i < 49; i++) begin
            tick();
            if (err_o !== 4'b0 || done_o !== 4'b0 || busy_o !== 1'b1) ok = 1'b0;
        end
        chk("to_quiet", ok, 1);
        tick();
        chk("to_err", err_o, 4'b1000);
        chk("to_nodone", done_o, 0);
        chk("to_busy", busy_o, 0);
        tick();
        chk("to_err_clr", err_o, 0);
        chk("to_busy_next", busy_o, 0);
        chk("to_grant_clr", grant_o, 0);
        req = 4'b1001;
        serve("after_to", 4'b0001, 8'h77, 4, 4'b0000);
        lock = 4'b0000;

        // tx_done on the exact timeout cycle
        req = 4'b0100;
        tick();
        tick();
        chk("coin_wr", tx_wr_o, 1);
        req = 4'b0000;
        for (int i = 0; i < 49; i++) tick();
        chk("coin_pre_err", err_o, 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("coin_done", done_o, 4'b0100);
        chk("coin_noerr", err_o, 0);
        tick();
        chk("coin_noerr2", err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
